// File: rtl/beamformer_controller.sv
// Frame sequencer for the BRAM beamformer datapath: load, filter, flush, beamform, read out.
// Optional watchdog on BEAMFORMING enabled by defining BFCTRL_TIMEOUT_EN.
module beamformer_controller #(
   parameter int N_SAMPLES    = 2048,
   parameter int FILTER_FLUSH = 6,
   parameter int N_OUT        = 1024,
   parameter int SAMPLE_INIT  = -2
`ifdef BFCTRL_TIMEOUT_EN
   , parameter int TIMEOUT_CYC = 4096
`endif
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        go,
   input  logic        usedataflag,
   input  logic        valid_out,
   output logic        dp_run,
   output logic        signalinen,
   output logic        start,
   output logic [10:0] signal_address,
   output logic [10:0] readin_address,
   output logic        filter_bram_output_write_en,
   output logic        startbeamformer,
   output logic        output_read_en,
   output logic [1:0]  slice_state,
   output logic [15:0] sample_index,
   output logic        sumouten,
   output logic [9:0]  sumout_address,
   output logic        busy,
   output logic        done
`ifdef BFCTRL_TIMEOUT_EN
   , output logic      timeout
`endif
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOADIN, S_FILT, S_FLUSH,
      S_BEAM, S_SUM, S_DONE
   } state_t;

   localparam int FW = (FILTER_FLUSH > 1) ?
                       $clog2(FILTER_FLUSH) : 1;
   localparam logic [10:0] SIG_LAST = 11'(N_SAMPLES - 1);
   localparam logic [9:0]  OUT_LAST = 10'(N_OUT - 1);
   localparam logic [15:0] IDX_INIT = 16'(SAMPLE_INIT);
   localparam logic [FW-1:0] FLUSH_LAST = FW'(FILTER_FLUSH - 1);

   state_t state, state_n;
   logic [FW-1:0] flush_cnt;
   logic ud_q1, ud_q2;
   logic fall;
   logic out_last;

   // ud_q2/ud_q1 form the registered edge detector (one cycle late)
   assign fall     = ud_q2 & ~ud_q1;
   assign out_last = (sumout_address == OUT_LAST);
   assign filter_bram_output_write_en = valid_out;

`ifdef BFCTRL_TIMEOUT_EN
   localparam int WW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYC - 1);
   logic [WW-1:0] wd_cnt;
   logic wd_hit;

   assign wd_hit = (wd_cnt == WD_LAST) && !fall;

   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt  <= '0;
         timeout <= 1'b0;
      end else begin
         timeout <= (state == S_BEAM) &&
                    !(fall && out_last) && wd_hit;
         if (state != S_BEAM || fall)
            wd_cnt <= '0;
         else
            wd_cnt <= wd_cnt + 1'b1;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         S_IDLE:   if (go) state_n = S_LOADIN;
         S_LOADIN: state_n = S_FILT;
         S_FILT:
            if (signal_address == SIG_LAST)
               state_n = S_FLUSH;
         S_FLUSH:
            if (flush_cnt == FLUSH_LAST)
               state_n = S_BEAM;
         S_BEAM: begin
            if (fall && out_last)
               state_n = S_SUM;
`ifdef BFCTRL_TIMEOUT_EN
            else if (wd_hit)
               state_n = S_IDLE;
`endif
         end
         S_SUM:    if (out_last) state_n = S_DONE;
         S_DONE:   state_n = S_IDLE;
         default:  state_n = S_IDLE;
      endcase
   end

   always_comb begin
      dp_run          = 1'b0;
      signalinen      = 1'b0;
      start           = 1'b0;
      startbeamformer = 1'b0;
      output_read_en  = 1'b0;
      sumouten        = 1'b0;
      busy            = 1'b1;
      done            = 1'b0;
      unique case (state)
         S_IDLE: busy = 1'b0;
         S_LOADIN: begin
            signalinen = 1'b1;
            dp_run     = 1'b1;
         end
         S_FILT: begin
            signalinen = 1'b1;
            dp_run     = 1'b1;
            start      = 1'b1;
         end
         S_FLUSH: begin
            dp_run = 1'b1;
            start  = 1'b1;
         end
         S_BEAM: begin
            startbeamformer = 1'b1;
            output_read_en  = 1'b1;
         end
         S_SUM:  sumouten = 1'b1;
         S_DONE: done = 1'b1;
         default: busy = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ud_q1          <= 1'b0;
         ud_q2          <= 1'b0;
         flush_cnt      <= '0;
         signal_address <= '0;
         readin_address <= '0;
         slice_state    <= '0;
         sample_index   <= IDX_INIT;
         sumout_address <= '0;
      end else begin
         ud_q1 <= usedataflag;
         ud_q2 <= ud_q1;
         unique case (state)
            S_LOADIN: begin
               signal_address <= '0;
               sumout_address <= '0;
            end
            S_FILT: begin
               flush_cnt <= '0;
               if (signal_address != SIG_LAST)
                  signal_address <= signal_address + 11'd1;
            end
            S_FLUSH: begin
               flush_cnt <= flush_cnt + 1'b1;
               if (flush_cnt == FLUSH_LAST) begin
                  readin_address <= '0;
                  sample_index   <= IDX_INIT;
                  slice_state    <= '0;
               end
            end
            S_BEAM: begin
               slice_state <= slice_state + 2'd1;
               if (slice_state != 2'd0)
                  sample_index <= sample_index + 16'd1;
               if (slice_state == 2'd3)
                  readin_address <= readin_address + 11'd1;
               if (fall)
                  sumout_address <= out_last ? '0 :
                                    sumout_address + 10'd1;
            end
            S_SUM:
               sumout_address <= sumout_address + 10'd1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_beamformer_controller.sv
// Directed bench for beamformer_controller: full frame, resets, passthrough
// and, with BFCTRL_TIMEOUT_EN, the watchdog at TIMEOUT_CYC=64.
module tb_beamformer_controller;

   logic        clk = 1'b0;
   logic        rst, go, usedataflag, valid_out;
   logic        dp_run, signalinen, start;
   logic [10:0] signal_address, readin_address;
   logic        filter_bram_output_write_en;
   logic        startbeamformer, output_read_en;
   logic [1:0]  slice_state;
   logic [15:0] sample_index;
   logic        sumouten;
   logic [9:0]  sumout_address;
   logic        busy, done;
`ifdef BFCTRL_TIMEOUT_EN
   logic        timeout;
`endif

   int vec  = 0;
   int miss = 0;

   always #5 clk = ~clk;

`ifdef BFCTRL_TIMEOUT_EN
   beamformer_controller #(.TIMEOUT_CYC(64)) dut (
`else
   beamformer_controller dut (
`endif
      .clk(clk), .rst(rst), .go(go),
      .usedataflag(usedataflag), .valid_out(valid_out),
      .dp_run(dp_run), .signalinen(signalinen),
      .start(start), .signal_address(signal_address),
      .readin_address(readin_address),
      .filter_bram_output_write_en(filter_bram_output_write_en),
      .startbeamformer(startbeamformer),
      .output_read_en(output_read_en),
      .slice_state(slice_state), .sample_index(sample_index),
      .sumouten(sumouten), .sumout_address(sumout_address),
      .busy(busy), .done(done)
`ifdef BFCTRL_TIMEOUT_EN
      , .timeout(timeout)
`endif
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; go = 1'b0; usedataflag = 1'b0; valid_out = 1'b0;
      tick; tick;
      rst = 1'b0;
      vec++;
      if (busy !== 1'b0) begin
         miss++; $display("FAIL reset_busy got %b want 0", busy);
      end
      vec++;
      if ({dp_run, signalinen, start, startbeamformer, output_read_en,
           sumouten, done, filter_bram_output_write_en} !== 8'b0) begin
         miss++;
         $display("FAIL reset_ctrl got %b%b%b%b%b%b%b want all 0",
                  dp_run, signalinen, start, startbeamformer,
                  output_read_en, sumouten, done);
      end
      vec++;
      if (signal_address !== 11'd0 || readin_address !== 11'd0 ||
          slice_state !== 2'd0 || sumout_address !== 10'd0) begin
         miss++;
         $display("FAIL reset_addr got sa=%0d ra=%0d sl=%0d so=%0d want 0",
                  signal_address, readin_address, slice_state,
                  sumout_address);
      end
      vec++;
      if (sample_index !== 16'hFFFE) begin
         miss++;
         $display("FAIL reset_sidx got %h want fffe", sample_index);
      end
`ifdef BFCTRL_TIMEOUT_EN
      vec++;
      if (timeout !== 1'b0) begin
         miss++; $display("FAIL reset_timeout got %b want 0", timeout);
      end
`endif
   endtask

   task automatic test_passthrough;
      valid_out = 1'b1; #1;
      vec++;
      if (filter_bram_output_write_en !== 1'b1) begin
         miss++;
         $display("FAIL wren_hi got %b want 1", filter_bram_output_write_en);
      end
      valid_out = 1'b0; #1;
      vec++;
      if (filter_bram_output_write_en !== 1'b0) begin
         miss++;
         $display("FAIL wren_lo got %b want 0", filter_bram_output_write_en);
      end
   endtask

   task automatic test_frame;
      int bad;
      logic [15:0] si_tab [0:5];
      logic [10:0] ra_tab [0:5];
      logic [1:0]  sl_tab [0:5];
      si_tab = '{16'hFFFE, 16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'h0001};
      ra_tab = '{11'd0, 11'd0, 11'd0, 11'd0, 11'd1, 11'd1};
      sl_tab = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      go = 1'b1; tick; go = 1'b0;
      vec++;
      if ({busy, signalinen, dp_run, start} !== 4'b1110) begin
         miss++;
         $display("FAIL loadin got bsy/sen/run/st=%b%b%b%b want 1110",
                  busy, signalinen, dp_run, start);
      end
      tick;
      bad = 0;
      for (int i = 0; i < 2048; i++) begin
         if (signal_address !== 11'(i) || start !== 1'b1 ||
             dp_run !== 1'b1)
            bad++;
         if (i == 100) go = 1'b1;
         if (i == 101) go = 1'b0;
         tick;
      end
      vec++;
      if (bad != 0) begin
         miss++; $display("FAIL filt_addr got %0d bad cycles want 0", bad);
      end
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         if (start !== 1'b1 || dp_run !== 1'b1 ||
             startbeamformer !== 1'b0 || signal_address !== 11'd2047)
            bad++;
         tick;
      end
      vec++;
      if (bad != 0) begin
         miss++; $display("FAIL flush got %0d bad cycles want 0", bad);
      end
      vec++;
      if ({dp_run, start, startbeamformer, output_read_en} !== 4'b0011) begin
         miss++;
         $display("FAIL beam_ctrl got %b%b%b%b want 0011",
                  dp_run, start, startbeamformer, output_read_en);
      end
      for (int j = 0; j < 6; j++) begin
         vec++;
         if (slice_state !== sl_tab[j] || sample_index !== si_tab[j] ||
             readin_address !== ra_tab[j]) begin
            miss++;
            $display("FAIL slice%0d got sl=%0d si=%h ra=%0d want %0d %h %0d",
                     j, slice_state, sample_index, readin_address,
                     sl_tab[j], si_tab[j], ra_tab[j]);
         end
         tick;
      end
      bad = 0;
      for (int k = 0; k < 1023; k++) begin
         usedataflag = 1'b1; tick;
         usedataflag = 1'b0; tick; tick;
         if (sumout_address !== 10'(k + 1) || sumouten !== 1'b0)
            bad++;
      end
      vec++;
      if (bad != 0) begin
         miss++; $display("FAIL sum_edges got %0d bad edges want 0", bad);
      end
      vec++;
      if (sumout_address !== 10'd1023 || startbeamformer !== 1'b1) begin
         miss++;
         $display("FAIL sum_1023 got so=%0d sbf=%b want 1023 1",
                  sumout_address, startbeamformer);
      end
      usedataflag = 1'b1; tick;
      usedataflag = 1'b0; tick; tick;
      vec++;
      if ({sumouten, startbeamformer, output_read_en} !== 3'b100 ||
          sumout_address !== 10'd0) begin
         miss++;
         $display("FAIL summing_entry got so=%0d ctl=%b%b%b want 0 100",
                  sumout_address, sumouten, startbeamformer, output_read_en);
      end
      bad = 0;
      for (int m = 0; m < 1024; m++) begin
         if (sumout_address !== 10'(m) || sumouten !== 1'b1 ||
             done !== 1'b0)
            bad++;
         tick;
      end
      vec++;
      if (bad != 0) begin
         miss++; $display("FAIL summing got %0d bad cycles want 0", bad);
      end
      vec++;
      if ({done, sumouten, busy} !== 3'b101) begin
         miss++;
         $display("FAIL done_pulse got dn/soe/bsy=%b%b%b want 101",
                  done, sumouten, busy);
      end
      tick;
      vec++;
      if ({done, busy} !== 2'b00) begin
         miss++;
         $display("FAIL done_end got dn/bsy=%b%b want 00", done, busy);
      end
   endtask

   task automatic test_rst_filtering;
      go = 1'b1; tick; go = 1'b0;
      repeat (11) tick;
      vec++;
      if (signal_address !== 11'd10) begin
         miss++;
         $display("FAIL rstf_pre got %0d want 10", signal_address);
      end
      rst = 1'b1; tick; rst = 1'b0;
      vec++;
      if (busy !== 1'b0 || signal_address !== 11'd0 ||
          {dp_run, start, signalinen} !== 3'b000) begin
         miss++;
         $display("FAIL rstf got bsy=%b sa=%0d ctl=%b%b%b want 0 0 000",
                  busy, signal_address, dp_run, start, signalinen);
      end
   endtask

   task automatic test_rst_beamforming;
      go = 1'b1; tick; go = 1'b0;
      repeat (2055) tick;
      usedataflag = 1'b1; tick;
      usedataflag = 1'b0; tick; tick;
      vec++;
      if (sumout_address !== 10'd1 || slice_state !== 2'd3 ||
          sample_index !== 16'h0000) begin
         miss++;
         $display("FAIL rstb_pre got so=%0d sl=%0d si=%h want 1 3 0000",
                  sumout_address, slice_state, sample_index);
      end
      rst = 1'b1; tick; rst = 1'b0;
      vec++;
      if (sample_index !== 16'hFFFE || slice_state !== 2'd0 ||
          readin_address !== 11'd0 || sumout_address !== 10'd0) begin
         miss++;
         $display("FAIL rstb_regs got si=%h sl=%0d ra=%0d so=%0d",
                  sample_index, slice_state, readin_address, sumout_address);
      end
      vec++;
      if ({busy, startbeamformer, output_read_en, done} !== 4'b0000) begin
         miss++;
         $display("FAIL rstb_ctl got %b%b%b%b want 0000",
                  busy, startbeamformer, output_read_en, done);
      end
      tick;
      vec++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         miss++;
         $display("FAIL rstb_nodone got dn=%b bsy=%b want 0 0", done, busy);
      end
   endtask

`ifdef BFCTRL_TIMEOUT_EN
   task automatic test_timeout;
      go = 1'b1; tick; go = 1'b0;
      repeat (2055) tick;
      repeat (63) tick;
      vec++;
      if (busy !== 1'b1 || timeout !== 1'b0) begin
         miss++;
         $display("FAIL to_pre got bsy=%b to=%b want 1 0", busy, timeout);
      end
      tick;
      vec++;
      if ({busy, timeout, done} !== 3'b010) begin
         miss++;
         $display("FAIL to_pulse got bsy/to/dn=%b%b%b want 010",
                  busy, timeout, done);
      end
      tick;
      vec++;
      if (timeout !== 1'b0 || done !== 1'b0) begin
         miss++;
         $display("FAIL to_end got to=%b dn=%b want 0 0", timeout, done);
      end
   endtask
`endif

   initial begin
      test_reset;
      test_passthrough;
      test_frame;
      test_rst_filtering;
      test_rst_beamforming;
`ifdef BFCTRL_TIMEOUT_EN
      test_timeout;
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
